intc_2_thread: RTL and testbench

INTC_2_THREAD -- requirements
Module: intc_2_thread

---
 rtl/intc_pkg.sv | 14 +
 rtl/intc_thread_arb.sv | 83 ++++++++
 rtl/intc_2_thread.sv | 76 +++++++
 tb/tb_intc_2_thread.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/intc_pkg.sv
// Shared types and defaults for the two-thread interrupt controller.
// Holds the per-thread arbiter state encoding and the source count default.
package intc_pkg;

    localparam int N_SRC_DEF = 8;
    localparam int CAUSE_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SERVE = 2'd2
    } arb_state_e;

endpackage

// File: rtl/intc_thread_arb.sv
// Per-thread request/ack FSM with a lowest-index priority encoder.
// Latency: intr one cycle after eligibility, cvalid one cycle after acknowledge; inta only honoured in REQ.
module intc_thread_arb
    import intc_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [N_SRC-1:0]   elig_i,
    input  logic               inta_i,
    output logic               intr_o,
    output logic               cvalid_o,
    output logic [CAUSE_W-1:0] cause_o,
    output logic [N_SRC-1:0]   clr_o
);

    arb_state_e         state_q;
    logic               intr_q;
    logic               cvalid_q;
    logic [CAUSE_W-1:0] cause_q;
    logic [CAUSE_W-1:0] sel_idx;
    logic               any_elig;

    // Scan downwards so the lowest set index wins.
    always_comb begin
        sel_idx  = '0;
        any_elig = |elig_i;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (elig_i[i]) sel_idx = CAUSE_W'(i);
        end
    end

    // Clear pulse coincides with the REQ->SERVE transition edge.
    always_comb begin
        clr_o = '0;
        if (state_q == REQ && inta_i && any_elig) clr_o = N_SRC'(1) << sel_idx;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            intr_q   <= 1'b0;
            cvalid_q <= 1'b0;
            cause_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cvalid_q <= 1'b0;
                    if (any_elig) begin
                        state_q <= REQ;
                        intr_q  <= 1'b1;
                    end
                end
                REQ: begin
                    if (!any_elig) begin
                        state_q <= IDLE;
                        intr_q  <= 1'b0;
                    end else if (inta_i) begin
                        state_q  <= SERVE;
                        intr_q   <= 1'b0;
                        cvalid_q <= 1'b1;
                        cause_q  <= sel_idx;
                    end
                end
                SERVE: begin
                    state_q  <= IDLE;
                    cvalid_q <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    intr_q   <= 1'b0;
                    cvalid_q <= 1'b0;
                end
            endcase
        end
    end

    assign intr_o   = intr_q;
    assign cvalid_o = cvalid_q;
    assign cause_o  = cause_q;

endmodule

// File: rtl/intc_2_thread.sv
// Edge-detecting interrupt controller routing pending sources to two CPU threads.
// Latency: src edge -> pending 1 cycle, intr 2 cycles; no backpressure beyond the per-thread inta handshake.
module intc_2_thread
    import intc_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_SRC-1:0]   src,
    input  logic [N_SRC-1:0]   route,
    input  logic [N_SRC-1:0]   mask,
    output logic               intr0,
    output logic               intr1,
    input  logic               inta0,
    input  logic               inta1,
    output logic [CAUSE_W-1:0] cause0,
    output logic [CAUSE_W-1:0] cause1,
    output logic               cvalid0,
    output logic               cvalid1,
    output logic [N_SRC-1:0]   pending
);

    logic [N_SRC-1:0] src_q;
    logic             armed_q;
    logic [N_SRC-1:0] pending_q;
    logic [N_SRC-1:0] pending_d;
    logic [N_SRC-1:0] src_edge_d;
    logic [N_SRC-1:0] elig0;
    logic [N_SRC-1:0] elig1;
    logic [N_SRC-1:0] clr0;
    logic [N_SRC-1:0] clr1;

    // First cycle after reset only primes src_q, so a level held across release is not an edge.
    assign src_edge_d = armed_q ? (src & ~src_q) : '0;
    assign pending_d  = (pending_q & ~clr0 & ~clr1) | src_edge_d;
    assign elig0      = pending_q & mask & ~route;
    assign elig1      = pending_q & mask & route;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src_q     <= '0;
            armed_q   <= 1'b0;
            pending_q <= '0;
        end else begin
            src_q     <= src;
            armed_q   <= 1'b1;
            pending_q <= pending_d;
        end
    end

    intc_thread_arb #(.N_SRC(N_SRC)) u_arb0 (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .elig_i   (elig0),
        .inta_i   (inta0),
        .intr_o   (intr0),
        .cvalid_o (cvalid0),
        .cause_o  (cause0),
        .clr_o    (clr0)
    );

    intc_thread_arb #(.N_SRC(N_SRC)) u_arb1 (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .elig_i   (elig1),
        .inta_i   (inta1),
        .intr_o   (intr1),
        .cvalid_o (cvalid1),
        .cause_o  (cause1),
        .clr_o    (clr1)
    );

    assign pending = pending_q;

endmodule

// File: tb/tb_intc_2_thread.sv
// Directed vector table plus randomized traffic checked against a behavioural model.
module tb_intc_2_thread;

    typedef struct packed {
        logic       rst_n;
        logic [7:0] src;
        logic [7:0] route;
        logic [7:0] mask;
        logic       inta0;
        logic       inta1;
    } in_t;

    typedef struct packed {
        logic       intr0;
        logic       intr1;
        logic       cv0;
        logic       cv1;
        logic [2:0] c0;
        logic [2:0] c1;
        logic [7:0] pend;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] src, route, mask, pending;
    logic       intr0, intr1, inta0, inta1, cvalid0, cvalid1;
    logic [2:0] cause0, cause1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    intc_2_thread #(.N_SRC(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .src     (src),
        .route   (route),
        .mask    (mask),
        .intr0   (intr0),
        .intr1   (intr1),
        .inta0   (inta0),
        .inta1   (inta1),
        .cause0  (cause0),
        .cause1  (cause1),
        .cvalid0 (cvalid0),
        .cvalid1 (cvalid1),
        .pending (pending)
    );

    // Behavioural model: a pending set, the last sampled src level, and for each
    // thread whether it is currently asking for service or reporting a cause.
    logic [7:0] m_pend, m_prev;
    bit         m_primed;
    bit         m_asking [2];
    bit         m_report [2];
    logic [2:0] m_cause  [2];

    function automatic int lowest(input logic [7:0] v);
        for (int k = 0; k < 8; k++) if (v[k]) return k;
        return -1;
    endfunction

    task automatic model_clock(input in_t x);
        logic [7:0] want [2];
        logic [7:0] taken;
        logic [7:0] rises;
        bit         ack [2];
        if (!x.rst_n) begin
            m_pend = 0; m_prev = 0; m_primed = 0;
            for (int t = 0; t < 2; t++) begin
                m_asking[t] = 0; m_report[t] = 0; m_cause[t] = 0;
            end
            return;
        end
        rises    = m_primed ? (x.src & ~m_prev) : 8'h00;
        m_prev   = x.src;
        m_primed = 1;
        want[0]  = m_pend & x.mask & ~x.route;
        want[1]  = m_pend & x.mask & x.route;
        ack[0]   = x.inta0;
        ack[1]   = x.inta1;
        taken    = 0;
        for (int t = 0; t < 2; t++) begin
            if (m_report[t]) begin
                m_report[t] = 0;
            end else if (m_asking[t]) begin
                if (want[t] == 0) begin
                    m_asking[t] = 0;
                end else if (ack[t]) begin
                    m_asking[t] = 0;
                    m_report[t] = 1;
                    m_cause[t]  = 3'(lowest(want[t]));
                    taken[lowest(want[t])] = 1'b1;
                end
            end else if (want[t] != 0) begin
                m_asking[t] = 1;
            end
        end
        m_pend = (m_pend & ~taken) | rises;
    endtask

    function automatic out_t model_out();
        out_t o;
        o.intr0 = m_asking[0];
        o.intr1 = m_asking[1];
        o.cv0   = m_report[0];
        o.cv1   = m_report[1];
        o.c0    = m_cause[0];
        o.c1    = m_cause[1];
        o.pend  = m_pend;
        return o;
    endfunction

    function automatic out_t dut_out();
        out_t o;
        o.intr0 = intr0;  o.intr1 = intr1;
        o.cv0   = cvalid0; o.cv1  = cvalid1;
        o.c0    = cause0; o.c1    = cause1;
        o.pend  = pending;
        return o;
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got intr=%b%b cv=%b%b c0=%0d c1=%0d pend=%h, want intr=%b%b cv=%b%b c0=%0d c1=%0d pend=%h",
                     name, act.intr0, act.intr1, act.cv0, act.cv1, act.c0, act.c1, act.pend,
                     exp.intr0, exp.intr1, exp.cv0, exp.cv1, exp.c0, exp.c1, exp.pend);
        end
    endtask

    // Drive on the falling edge, step the model at the rising edge, sample 1ns later.
    task automatic step(input in_t x, input string name);
        @(negedge clk);
        rst_n = x.rst_n; src = x.src; route = x.route; mask = x.mask;
        inta0 = x.inta0; inta1 = x.inta1;
        @(posedge clk);
        model_clock(x);
        #1;
        check(name, dut_out(), model_out());
    endtask

    function automatic vec_t mk(input logic r, input logic [7:0] s, rt, mk_, input logic a0, a1,
                                input logic i0, i1, v0, v1, input logic [2:0] c0, c1,
                                input logic [7:0] p);
        vec_t v;
        v.i = '{rst_n: r, src: s, route: rt, mask: mk_, inta0: a0, inta1: a1};
        v.o = '{intr0: i0, intr1: i1, cv0: v0, cv1: v1, c0: c0, c1: c1, pend: p};
        return v;
    endfunction

    vec_t tbl [$];

    initial begin
        in_t  x;
        rst_n = 0; src = 0; route = 0; mask = 0; inta0 = 0; inta1 = 0;

        //            rst src    route  mask   a0 a1  i0 i1 v0 v1 c0 c1 pend
        tbl.push_back(mk(0, 8'h00, 8'h00, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00)); // reset
        tbl.push_back(mk(1, 8'h00, 8'h00, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h04, 8'h00, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 8'h04)); // single source
        tbl.push_back(mk(1, 8'h04, 8'h00, 8'hFF, 0, 0, 1, 0, 0, 0, 0, 0, 8'h04));
        tbl.push_back(mk(1, 8'h04, 8'h00, 8'hFF, 1, 0, 0, 0, 1, 0, 2, 0, 8'h00));
        tbl.push_back(mk(1, 8'h04, 8'h00, 8'hFF, 0, 0, 0, 0, 0, 0, 2, 0, 8'h00));
        tbl.push_back(mk(1, 8'h26, 8'h00, 8'hFF, 0, 0, 0, 0, 0, 0, 2, 0, 8'h22)); // bits 1,5
        tbl.push_back(mk(1, 8'h26, 8'h00, 8'hFF, 0, 0, 1, 0, 0, 0, 2, 0, 8'h22));
        tbl.push_back(mk(1, 8'h26, 8'h00, 8'hFF, 1, 0, 0, 0, 1, 0, 1, 0, 8'h20));
        tbl.push_back(mk(1, 8'h26, 8'h00, 8'hFF, 0, 0, 0, 0, 0, 0, 1, 0, 8'h20)); // gap
        tbl.push_back(mk(1, 8'h26, 8'h00, 8'hFF, 0, 0, 1, 0, 0, 0, 1, 0, 8'h20));
        tbl.push_back(mk(1, 8'h26, 8'h00, 8'hFF, 1, 0, 0, 0, 1, 0, 5, 0, 8'h00));
        tbl.push_back(mk(1, 8'h26, 8'h00, 8'hFF, 0, 0, 0, 0, 0, 0, 5, 0, 8'h00));
        tbl.push_back(mk(1, 8'hA7, 8'h80, 8'hFF, 0, 0, 0, 0, 0, 0, 5, 0, 8'h81)); // two threads
        tbl.push_back(mk(1, 8'hA7, 8'h80, 8'hFF, 0, 0, 1, 1, 0, 0, 5, 0, 8'h81));
        tbl.push_back(mk(1, 8'hA7, 8'h80, 8'hFF, 1, 1, 0, 0, 1, 1, 0, 7, 8'h00));
        tbl.push_back(mk(1, 8'hA7, 8'h80, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 7, 8'h00));
        tbl.push_back(mk(1, 8'hAF, 8'h80, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 7, 8'h08)); // mask drop
        tbl.push_back(mk(1, 8'hAF, 8'h80, 8'hFF, 0, 0, 1, 0, 0, 0, 0, 7, 8'h08));
        tbl.push_back(mk(1, 8'hAF, 8'h80, 8'hF7, 0, 0, 0, 0, 0, 0, 0, 7, 8'h08));
        tbl.push_back(mk(1, 8'hAF, 8'h80, 8'hF7, 1, 0, 0, 0, 0, 0, 0, 7, 8'h08));
        tbl.push_back(mk(1, 8'hAF, 8'h80, 8'hFF, 0, 0, 1, 0, 0, 0, 0, 7, 8'h08));
        tbl.push_back(mk(1, 8'hAF, 8'h80, 8'hFF, 1, 0, 0, 0, 1, 0, 3, 7, 8'h00));
        tbl.push_back(mk(1, 8'hAF, 8'h80, 8'hFF, 0, 0, 0, 0, 0, 0, 3, 7, 8'h00));
        tbl.push_back(mk(1, 8'hEF, 8'hC0, 8'hFF, 0, 0, 0, 0, 0, 0, 3, 7, 8'h40)); // reset mid-request
        tbl.push_back(mk(1, 8'hEF, 8'hC0, 8'hFF, 0, 0, 0, 1, 0, 0, 3, 7, 8'h40));
        tbl.push_back(mk(0, 8'hEF, 8'hC0, 8'hFF, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'hEF, 8'hC0, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'hEF, 8'hC0, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00));

        foreach (tbl[n]) begin
            step(tbl[n].i, $sformatf("vec%0d", n));
            check($sformatf("vec%0d_tbl", n), dut_out(), tbl[n].o);
        end

        // Same-cycle clear and re-set of one bit: the new edge must survive.
        x = '{rst_n: 1, src: 8'h00, route: 8'h00, mask: 8'hFF, inta0: 0, inta1: 0};
        step(x, "setclr_a");
        x.src = 8'h01; step(x, "setclr_b");
        x.src = 8'h00; step(x, "setclr_c");
        x.src = 8'h01; x.inta0 = 1; step(x, "setclr_d");
        check("setclr_kept", dut_out(),
              '{intr0: 0, intr1: 0, cv0: 1, cv1: 0, c0: 3'd0, c1: 3'd0, pend: 8'h01});
        x.inta0 = 0; step(x, "setclr_e");

        // Randomized traffic against the model.
        x = '{rst_n: 1, src: 8'h00, route: 8'h0F, mask: 8'hFF, inta0: 0, inta1: 0};
        for (int n = 0; n < 3000; n++) begin
            x.rst_n = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 2) == 0) x.src = x.src ^ (8'($urandom) & 8'($urandom));
            if ($urandom_range(0, 19) == 0) x.route = 8'($urandom);
            if ($urandom_range(0, 9) == 0) x.mask = 8'($urandom) | 8'($urandom);
            x.inta0 = 1'($urandom);
            x.inta1 = 1'($urandom);
            step(x, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
